// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that frames one payload word per grant onto a single-word uart tx path.
// Build option UART_TX_SCHED_CSUM_EN appends a 16-bit wrap-around checksum word to every frame.
module uart_tx_sched #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0][15:0] req_data,
   output logic [NREQ-1:0]       req_ack,
   output logic                  u_send_data,
   output logic [15:0]           u_tx_num,
   input  logic                  u_tx_ready,
   output logic                  busy,
   output logic                  err_timeout,
   output logic [2:0]            dbg_state
);

   localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   // Handshake: a requester holds req_valid (and its data) until it sees req_ack,
   // a one-cycle pulse given only in IDLE; the uart accepts a word when u_send_data
   // pulses while u_tx_ready is high.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR    = 3'd1,
      S_WAIT_H = 3'd2,
      S_DATA   = 3'd3,
      S_WAIT_D = 3'd4
`ifdef UART_TX_SCHED_CSUM_EN
      ,
      S_CSUM   = 3'd5,
      S_WAIT_C = 3'd6
`endif
   } state_e;

   state_e          state_q, state_d;
   logic [RW-1:0]   rr_q, rr_d;
   logic [RW-1:0]   id_q, id_d;
   logic [15:0]     data_q, data_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            first_q, first_d;
   logic            err_q, err_d;
   logic [15:0]     hdr_word;
   logic            found;
   logic [RW-1:0]   gnt;
   int              cand;

   assign hdr_word = {8'hA5, 8'(id_q)};
`ifdef UART_TX_SCHED_CSUM_EN
   logic [15:0] csum_word;
   assign csum_word = hdr_word + data_q;
`endif

   // First valid requester at or after the rr pointer, wrapping.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      cand  = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(rr_q) + k) % NREQ;
         if (!found && req_valid[RW'(cand)]) begin
            found = 1'b1;
            gnt   = RW'(cand);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      id_d        = id_q;
      data_d      = data_q;
      first_d     = 1'b0;
      err_d       = err_q;
      cnt_d       = cnt_q;
      req_ack     = '0;
      u_send_data = 1'b0;
      u_tx_num    = '0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               req_ack[gnt] = 1'b1;
               id_d         = gnt;
               data_d       = req_data[gnt];
               rr_d         = RW'((int'(gnt) + 1) % NREQ);
               state_d      = S_HDR;
            end
         end
         S_HDR: begin
            u_tx_num = hdr_word;
            if (u_tx_ready) begin
               u_send_data = 1'b1;
               first_d     = 1'b1;
               state_d     = S_WAIT_H;
            end
         end
         // The uart drops tx_ready one cycle late, so the first WAIT cycle is blind.
         S_WAIT_H: begin
            u_tx_num = hdr_word;
            if (!first_q && u_tx_ready) state_d = S_DATA;
         end
         S_DATA: begin
            u_tx_num = data_q;
            if (u_tx_ready) begin
               u_send_data = 1'b1;
               first_d     = 1'b1;
               state_d     = S_WAIT_D;
            end
         end
         S_WAIT_D: begin
            u_tx_num = data_q;
`ifdef UART_TX_SCHED_CSUM_EN
            if (!first_q && u_tx_ready) state_d = S_CSUM;
`else
            if (!first_q && u_tx_ready) state_d = S_IDLE;
`endif
         end
`ifdef UART_TX_SCHED_CSUM_EN
         S_CSUM: begin
            u_tx_num = csum_word;
            if (u_tx_ready) begin
               u_send_data = 1'b1;
               first_d     = 1'b1;
               state_d     = S_WAIT_C;
            end
         end
         S_WAIT_C: begin
            u_tx_num = csum_word;
            if (!first_q && u_tx_ready) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Watchdog: a state that has not moved after TIMEOUT cycles drops the frame.
      if (TIMEOUT > 0 && state_q != S_IDLE && state_d == state_q &&
          cnt_q == CW'(TIMEOUT - 1)) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
      end

      if (state_d != state_q || state_q == S_IDLE) begin
         cnt_d = '0;
      end else if (cnt_q != {CW{1'b1}}) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         err_q   <= err_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign err_timeout = err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic checked against a frame-level model
// (round-robin pick over the valid vector, header/payload/checksum words computed arithmetically).
`timescale 1ns/1ps
module tb_uart_tx_sched;
   localparam int NREQ = 4;
   localparam int TMO  = 16;
`ifdef UART_TX_SCHED_CSUM_EN
   localparam int NW = 3;
`else
   localparam int NW = 2;
`endif

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0][15:0] req_data;
   logic [NREQ-1:0]       req_ack;
   logic                  u_send_data;
   logic [15:0]           u_tx_num;
   logic                  u_tx_ready;
   logic                  busy;
   logic                  err_timeout;
   logic [2:0]            dbg_state;

   int errors = 0;
   int checks = 0;

   logic [15:0]     got_q[$];
   logic [15:0]     exp_q[$];
   int              ack_id_q[$];
   logic [15:0]     ack_dat_q[$];
   logic [NREQ-1:0] ack_v_q[$];
   logic [NREQ-1:0] last_ack = '0;
   int              proto_viol = 0;
   int              resp_mode = 0;
   bit              rand_ready = 1'b0;
   bit              rand_req = 1'b0;

   uart_tx_sched #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ack     (req_ack),
      .u_send_data (u_send_data),
      .u_tx_num    (u_tx_num),
      .u_tx_ready  (u_tx_ready),
      .busy        (busy),
      .err_timeout (err_timeout),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   // Monitor on the falling edge: words handed to the uart, grants, protocol sanity.
   always @(negedge clk) begin
      last_ack = req_ack;
      if (reset_n) begin
         if (u_send_data) got_q.push_back(u_tx_num);
         if (req_ack != '0) begin
            if ($countones(req_ack) != 1 || busy || (req_ack & ~req_valid) != '0) proto_viol++;
            for (int i = 0; i < NREQ; i++) begin
               if (req_ack[i]) begin
                  ack_id_q.push_back(i);
                  ack_dat_q.push_back(req_data[i]);
                  ack_v_q.push_back(req_valid);
               end
            end
         end
         if (!busy && req_valid != '0 && req_ack == '0) proto_viol++;
      end
   end

   // ---------------- reference model ----------------
   function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic void push_frame(input int id, input logic [15:0] d);
      logic [15:0] h;
      h = 16'hA500 + 16'(id);
      exp_q.push_back(h);
      exp_q.push_back(d);
      if (NW == 3) exp_q.push_back(h + d);
   endfunction

   // ---------------- drivers ----------------
   task automatic do_reset();
      reset_n    = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      u_tx_ready = 1'b0;
      resp_mode  = 0;
      rand_ready = 1'b0;
      rand_req   = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      ack_id_q.delete();
      ack_dat_q.delete();
      ack_v_q.delete();
      proto_viol = 0;
   endtask

   // One clock: requesters react to last cycle's ack (1: drop, 2: new data), optional random traffic.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (last_ack[i]) begin
            if (resp_mode == 2) req_data[i] = 16'($urandom);
            else if (resp_mode == 1) req_valid[i] = 1'b0;
         end else if (rand_req) begin
            if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
               req_valid[i] = 1'b1;
               req_data[i]  = 16'($urandom);
            end else if (req_valid[i] && $urandom_range(0, 31) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      if (rand_ready) u_tx_ready = ($urandom_range(0, 3) != 0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (req_ack !== '0) begin errors++; $display("FAIL reset_ack got=%b exp=0000", req_ack); end
      checks++; if (u_send_data !== 1'b0) begin errors++; $display("FAIL reset_send got=%b exp=0", u_send_data); end
      checks++; if (u_tx_num !== 16'h0) begin errors++; $display("FAIL reset_num got=%h exp=0000", u_tx_num); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
   endtask

   task automatic test_single();
      do_reset();
      u_tx_ready = 1'b1;
      resp_mode  = 1;
      @(posedge clk);
      #1;
      req_valid    = 4'b0100;
      req_data[2]  = 16'h1234;
      #1;
      checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b exp=0100", req_ack); end
      push_frame(2, 16'h1234);
      tick();
      #1;
      checks++;
      if (u_send_data !== 1'b1 || u_tx_num !== 16'hA502) begin
         errors++; $display("FAIL single_hdr_latency got send=%b num=%h exp send=1 num=a502", u_send_data, u_tx_num);
      end
      repeat (20) tick();
      checks++; if (ack_id_q.size() != 1) begin errors++; $display("FAIL single_nacks got=%0d exp=1", ack_id_q.size()); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL single_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_round_robin();
      int n;
      int rr;
      int e;
      int order[5];
      order = '{0, 1, 2, 3, 0};
      do_reset();
      u_tx_ready = 1'b1;
      resp_mode  = 2;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) req_data[i] = 16'($urandom);
      req_valid = 4'b1111;
      n = 0;
      while (ack_id_q.size() < 5 && n < 200) begin tick(); n++; end
      req_valid = '0;
      repeat (20) tick();
      checks++; if (ack_id_q.size() != 5) begin errors++; $display("FAIL rr_nacks got=%0d exp=5", ack_id_q.size()); end
      rr = 0;
      for (int k = 0; k < ack_id_q.size() && k < 5; k++) begin
         checks++; if (ack_id_q[k] != order[k]) begin errors++; $display("FAIL rr_order%0d got=%0d exp=%0d", k, ack_id_q[k], order[k]); end
         e = rr_pick(ack_v_q[k], rr);
         push_frame(e, ack_dat_q[k]);
         if (e >= 0) rr = (e + 1) % NREQ;
      end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rr_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
      checks++; if (proto_viol != 0) begin errors++; $display("FAIL rr_protocol got=%0d exp=0", proto_viol); end
   endtask

   task automatic test_wrap();
      int n;
      int order[3];
      order = '{2, 0, 1};
      do_reset();
      u_tx_ready = 1'b1;
      resp_mode  = 1;
      @(posedge clk);
      #1;
      req_valid   = 4'b0100;
      req_data[2] = 16'($urandom);
      n = 0;
      while ((ack_id_q.size() < 1 || busy) && n < 60) begin tick(); n++; end
      req_data[0] = 16'($urandom);
      req_data[1] = 16'($urandom);
      req_valid   = 4'b0011;
      n = 0;
      while (ack_id_q.size() < 3 && n < 100) begin tick(); n++; end
      repeat (20) tick();
      checks++; if (ack_id_q.size() != 3) begin errors++; $display("FAIL wrap_nacks got=%0d exp=3", ack_id_q.size()); end
      for (int k = 0; k < ack_id_q.size() && k < 3; k++) begin
         checks++; if (ack_id_q[k] != order[k]) begin errors++; $display("FAIL wrap_order%0d got=%0d exp=%0d", k, ack_id_q[k], order[k]); end
         push_frame(order[k], ack_dat_q[k]);
      end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL wrap_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] d;
      do_reset();
      u_tx_ready = 1'b1;
      resp_mode  = 1;
      d = 16'($urandom);
      @(posedge clk);
      #1;
      req_valid   = 4'b0010;
      req_data[1] = d;
      tick();
      tick();
      tick();
      tick();
      u_tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++; if (u_send_data !== 1'b0) begin errors++; $display("FAIL bp_hold_send%0d got=%b exp=0", k, u_send_data); end
         checks++; if (u_tx_num !== d) begin errors++; $display("FAIL bp_hold_num%0d got=%h exp=%h", k, u_tx_num, d); end
      end
      @(posedge clk);
      #1 u_tx_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (u_send_data !== 1'b1 || u_tx_num !== d) begin
         errors++; $display("FAIL bp_release got send=%b num=%h exp send=1 num=%h", u_send_data, u_tx_num, d);
      end
      repeat (20) tick();
      push_frame(1, d);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_random();
      int rr;
      int e;
      do_reset();
      u_tx_ready = 1'b1;
      resp_mode  = 1;
      rand_req   = 1'b1;
      rand_ready = 1'b1;
      repeat (1500) tick();
      rand_req   = 1'b0;
      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid  = '0;
      u_tx_ready = 1'b1;
      repeat (40) tick();
      checks++; if (ack_id_q.size() < 20) begin errors++; $display("FAIL rand_activity got=%0d exp>=20", ack_id_q.size()); end
      rr = 0;
      for (int k = 0; k < ack_id_q.size(); k++) begin
         e = rr_pick(ack_v_q[k], rr);
         checks++; if (ack_id_q[k] != e) begin errors++; $display("FAIL rand_grant%0d got=%0d exp=%0d", k, ack_id_q[k], e); end
         push_frame(e, ack_dat_q[k]);
         if (e >= 0) rr = (e + 1) % NREQ;
      end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
      checks++; if (proto_viol != 0) begin errors++; $display("FAIL rand_protocol got=%0d exp=0", proto_viol); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rand_err got=%b exp=0", err_timeout); end
   endtask

   task automatic test_timeout();
      int n;
      int order[3];
      logic [15:0] d1;
      order = '{0, 1, 0};
      do_reset();
      u_tx_ready = 1'b1;
      resp_mode  = 1;
      @(posedge clk);
      #1;
      req_valid   = 4'b0001;
      req_data[0] = 16'($urandom);
      tick();
      tick();
      u_tx_ready = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      checks++; if (n != TMO) begin errors++; $display("FAIL tmo_cycles got=%0d exp=%0d", n, TMO); end
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b exp=1", err_timeout); end
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL tmo_npulses got=%0d exp=1", got_q.size()); end
      repeat (5) tick();
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", err_timeout); end
      exp_q.push_back(16'hA500);
      d1 = 16'($urandom);
      u_tx_ready  = 1'b1;
      req_data[1] = d1;
      req_valid   = 4'b0011;
      n = 0;
      while (ack_id_q.size() < 3 && n < 100) begin tick(); n++; end
      repeat (20) tick();
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky_after got=%b exp=1", err_timeout); end
      checks++; if (ack_id_q.size() != 3) begin errors++; $display("FAIL tmo_nacks got=%0d exp=3", ack_id_q.size()); end
      for (int k = 0; k < ack_id_q.size() && k < 3; k++) begin
         checks++; if (ack_id_q[k] != order[k]) begin errors++; $display("FAIL tmo_order%0d got=%0d exp=%0d", k, ack_id_q[k], order[k]); end
         if (k > 0) push_frame(order[k], ack_dat_q[k]);
      end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL tmo_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL tmo_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
   endtask

   // Runs straight after test_timeout so err_timeout is still set when reset hits.
   task automatic test_reset_mid();
      u_tx_ready = 1'b1;
      resp_mode  = 1;
      @(posedge clk);
      #1;
      req_valid   = 4'b0100;
      req_data[2] = 16'($urandom);
      repeat (5) tick();
      u_tx_ready = 1'b0;
      tick();
      #1;
      checks++; if (busy !== 1'b1 || err_timeout !== 1'b1) begin errors++; $display("FAIL rmid_pre got busy=%b err=%b exp busy=1 err=1", busy, err_timeout); end
      req_valid = '0;
      reset_n   = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      checks++; if (u_send_data !== 1'b0) begin errors++; $display("FAIL rmid_send got=%b exp=0", u_send_data); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rmid_err got=%b exp=0", err_timeout); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < NREQ; i++) req_data[i] = 16'($urandom);
      u_tx_ready = 1'b1;
      req_valid  = 4'b1111;
      #1;
      checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant got=%b exp=0001", req_ack); end
      tick();
      req_valid = '0;
      repeat (20) tick();
   endtask

   initial begin
      reset_n    = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      u_tx_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_backpressure();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
